mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arb_wdog.sv | 47 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the mem_arbiter slice:
//   - arb_state_e : arbiter FSM states (IDLE / IF_BUSY / D_BUSY)
//   - owner_e     : which requester won the current grant
//   - STARVE_MAX_DEF, TIMEOUT_DEF : default parameter values
//   - starve_cnt_w() : width of the starvation counter (never below 3 bits)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;

    // Counter must hold STARVE_MAX itself; keep at least 3 bits.
    function automatic int unsigned starve_cnt_w(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the data port, the single-port memory port and the
// arbiter status flags.
//   slave  : the arbiter's view (requests and memory response in, the rest out)
//   master : the environment's view (requesters + memory model)
// Parameters: ADDR_W, DATA_W.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    // Data (MEM stage) port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    // Single-port memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    // Status
    logic              arb_busy;
    logic              arb_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, arb_busy, arb_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, arb_busy, arb_err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// -----------------------------------------------------------------------------
// mem_arb_wdog
// Busy-cycle watchdog for mem_arbiter (only built with MEM_ARB_TIMEOUT_EN).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : grant pulse, restarts the count
//   en_i       : arbiter is busy, count this cycle
//   expire_o   : high in the LIMIT-th busy cycle since the last clear
// Parameter: LIMIT (cycles).
// -----------------------------------------------------------------------------
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned    CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count holds k-1 in the k-th busy cycle, so expiry lands in cycle LIMIT.
    assign expire_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter (instruction fetch vs. data) in front of one
// single-port memory. Data wins by default; after STARVE_MAX consecutive data
// grants with a fetch waiting, the fetch is forced through. Every transaction
// ends with one IDLE bubble cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_arbiter_if.slave (fetch port, data port, memory port,
//                arb_busy, arb_err)
// Parameters: ADDR_W, DATA_W, STARVE_MAX, TIMEOUT.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that ends a
// transaction after TIMEOUT busy cycles with no mem_ack and sets arb_err.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned   SW         = starve_cnt_w(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e        state_q;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_req_q;
    logic              mem_we_q;

    logic              grant_d;
    owner_e            owner_d;
    logic              wdog_expire;
    logic              busy;
    logic              done;

    assign busy = (state_q != IDLE);
    assign done = busy && (bus.mem_ack || wdog_expire);

    // Arbitration, evaluated only in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        grant_d  = 1'b0;
        owner_d  = OWN_IF;
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (bus.d_req && !(bus.if_req && starve_q == STARVE_LIM)) begin
                grant_d = 1'b1;
                owner_d = OWN_D;
                if (bus.if_req) begin
                    starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
                end else begin
                    starve_d = '0;
                end
            end else if (bus.if_req) begin
                grant_d  = 1'b1;
                owner_d  = OWN_IF;
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the latched address/data fields are reset as well, so
            // mem_addr/mem_wdata come out of reset as zero rather than X.
            state_q   <= IDLE;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here updates from the values present before the edge.
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q   <= (owner_d == OWN_D) ? D_BUSY : IF_BUSY;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (owner_d == OWN_D) && bus.d_we;
                        addr_q    <= (owner_d == OWN_D) ? bus.d_addr : bus.if_addr;
                        wdata_q   <= (owner_d == OWN_D) ? bus.d_wdata : '0;
                    end
                end
                default: begin
                    // Back to IDLE for the mandatory bubble; addr/wdata hold.
                    if (done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic arb_err_q;

    mem_arb_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (grant_d),
        .en_i     (busy),
        .expire_o (wdog_expire)
    );

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arb_err_q <= 1'b0;
        end else if (wdog_expire) begin
            arb_err_q <= 1'b1;
        end
    end

    assign bus.arb_err = arb_err_q;
`else
    assign wdog_expire = 1'b0;
    assign bus.arb_err = 1'b0;
`endif

    // Ready follows mem_ack combinationally; a watchdog expiry also completes
    // the transaction but returns zero data.
    assign bus.if_ready  = (state_q == IF_BUSY) && (bus.mem_ack || wdog_expire);
    assign bus.d_ready   = (state_q == D_BUSY)  && (bus.mem_ack || wdog_expire);
    assign bus.if_rdata  = ((state_q == IF_BUSY) && bus.mem_ack) ? bus.mem_rdata : '0;
    assign bus.d_rdata   = ((state_q == D_BUSY)  && bus.mem_ack) ? bus.mem_rdata : '0;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.arb_busy  = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change on the falling
// edge, outputs are sampled 1 ns later. Works with or without
// MEM_ARB_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TIMEOUT    (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic        exp_fetch;
        logic [31:0] exp_addr;

        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_rdata  = '0;
        bus.mem_ack    = 1'b0;

        // ---------------- reset state
        cyc();
        cyc(); #1;
        check("rst_mem_req",  bus.mem_req,  0);
        check("rst_mem_we",   bus.mem_we,   0);
        check("rst_if_ready", bus.if_ready, 0);
        check("rst_d_ready",  bus.d_ready,  0);
        check("rst_busy",     bus.arb_busy, 0);
        check("rst_err",      bus.arb_err,  0);
        check("rst_mem_addr", bus.mem_addr, 0);

        // ---------------- fetch only, ack two cycles after mem_req
        cyc(); rst_n = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000; #1;
        check("f_idle_busy", bus.arb_busy, 0);
        cyc(); #1;
        check("f_mem_req",  bus.mem_req,  1);
        check("f_mem_we",   bus.mem_we,   0);
        check("f_mem_addr", bus.mem_addr, 32'h0040_0000);
        check("f_busy",     bus.arb_busy, 1);
        check("f_rdy_early", bus.if_ready, 0);
        cyc(); #1;
        check("f_rdy_wait", bus.if_ready, 0);
        check("f_req_wait", bus.mem_req,  1);
        cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2008_0005; #1;
        check("f_if_ready", bus.if_ready, 1);
        check("f_if_rdata", bus.if_rdata, 32'h2008_0005);
        check("f_d_ready",  bus.d_ready,  0);
        check("f_d_rdata",  bus.d_rdata,  0);
        cyc(); bus.mem_ack = 1'b0; bus.if_req = 1'b0; #1;
        check("f_bubble_busy",  bus.arb_busy, 0);
        check("f_bubble_req",   bus.mem_req,  0);
        check("f_bubble_rdy",   bus.if_ready, 0);
        check("f_bubble_rdata", bus.if_rdata, 0);
        check("f_addr_hold",    bus.mem_addr, 32'h0040_0000);

        // ---------------- mem_ack while IDLE is ignored
        cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_FFFF; #1;
        check("idle_ack_if_rdy", bus.if_ready, 0);
        check("idle_ack_d_rdy",  bus.d_ready,  0);
        check("idle_ack_rdata",  bus.d_rdata,  0);
        cyc(); bus.mem_ack = 1'b0; #1;
        check("idle_ack_busy", bus.arb_busy, 0);
        check("idle_ack_req",  bus.mem_req,  0);

        // ---------------- simultaneous requests: store first, fetch after bubble
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0004;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        cyc(); #1;
        check("s_mem_req",   bus.mem_req,   1);
        check("s_mem_we",    bus.mem_we,    1);
        check("s_mem_addr",  bus.mem_addr,  32'h1001_0000);
        check("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678; #1;
        check("s_d_ready",  bus.d_ready,  1);
        check("s_if_ready", bus.if_ready, 0);
        check("s_d_rdata",  bus.d_rdata,  32'h1234_5678);
        cyc(); bus.mem_ack = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; #1;
        check("s_bubble_busy", bus.arb_busy, 0);
        check("s_bubble_we",   bus.mem_we,   0);
        cyc(); #1;
        check("s_fetch_req",  bus.mem_req,  1);
        check("s_fetch_we",   bus.mem_we,   0);
        check("s_fetch_addr", bus.mem_addr, 32'h0040_0004);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013; #1;
        check("s_fetch_rdy",   bus.if_ready, 1);
        check("s_fetch_drdy",  bus.d_ready,  0);
        cyc(); bus.mem_ack = 1'b0; bus.if_req = 1'b0; #1;
        check("s_end_busy", bus.arb_busy, 0);

        // ---------------- both held: 4 data grants then 1 fetch, repeating
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0010;
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0008;
        for (int i = 0; i < 10; i++) begin
            exp_fetch = ((i % 5) == 4);
            exp_addr  = exp_fetch ? 32'h0040_0008 : 32'h1001_0010;
            cyc(); #1;
            check($sformatf("st_addr_%0d", i), bus.mem_addr, exp_addr);
            cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h100 + i; #1;
            check($sformatf("st_if_rdy_%0d", i), bus.if_ready, exp_fetch);
            check($sformatf("st_d_rdy_%0d", i),  bus.d_ready,  !exp_fetch);
            cyc(); bus.mem_ack = 1'b0; #1;
            check($sformatf("st_bubble_%0d", i), bus.arb_busy, 0);
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;

        // ---------------- reset in D_BUSY abandons the store, then re-arbitrates
        cyc(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0020; bus.d_wdata = 32'h0000_CAFE; #1;
        cyc(); #1;
        check("r_busy_before", bus.arb_busy, 1);
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_000C; rst_n = 1'b0;
        cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555; #1;
        check("r_mem_req",  bus.mem_req,  0);
        check("r_busy",     bus.arb_busy, 0);
        check("r_d_ready",  bus.d_ready,  0);
        check("r_mem_addr", bus.mem_addr, 0);
        bus.mem_ack = 1'b0; rst_n = 1'b1;
        cyc(); #1;
        check("r_regrant_we",   bus.mem_we,   1);
        check("r_regrant_addr", bus.mem_addr, 32'h1001_0020);
        bus.mem_ack = 1'b1; #1;
        check("r_regrant_rdy", bus.d_ready, 1);
        cyc(); bus.mem_ack = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; #1;
        cyc(); #1;
        check("r_fetch_addr", bus.mem_addr, 32'h0040_000C);
        bus.mem_ack = 1'b1; #1;
        check("r_fetch_rdy", bus.if_ready, 1);
        cyc(); bus.mem_ack = 1'b0; bus.if_req = 1'b0; #1;

        // ---------------- request dropped mid-transaction still completes once
        cyc(); bus.d_req = 1'b1; bus.d_addr = 32'h1001_0040; #1;
        cyc(); bus.d_req = 1'b0; #1;
        check("drop_busy", bus.arb_busy, 1);
        cyc(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D; #1;
        check("drop_d_ready", bus.d_ready, 1);
        check("drop_d_rdata", bus.d_rdata, 32'h0BAD_F00D);
        cyc(); bus.mem_ack = 1'b0; #1;
        cyc(); #1;
        check("drop_no_retry", bus.arb_busy, 0);

        // ---------------- no mem_ack: watchdog (if built) or wait forever
        bus.mem_rdata = 32'hAAAA_AAAA;
        cyc(); bus.d_req = 1'b1; bus.d_addr = 32'h1001_0030; #1;
        cyc(); bus.d_req = 1'b0; #1;    // first busy cycle
        check("to_busy_1", bus.arb_busy, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 2; k < 64; k++) begin
            cyc(); #1;
            check($sformatf("to_wait_%0d", k), bus.d_ready, 0);
        end
        cyc(); #1;                      // 64th busy cycle
        check("to_d_ready", bus.d_ready,  1);
        check("to_d_rdata", bus.d_rdata,  0);
        check("to_if_rdy",  bus.if_ready, 0);
        cyc(); #1;
        check("to_idle", bus.arb_busy, 0);
        check("to_err",  bus.arb_err,  1);
        cyc(); cyc(); #1;
        check("to_err_hold", bus.arb_err, 1);
`else
        for (int k = 2; k < 100; k++) begin
            cyc();
        end
        #1;
        check("nowd_busy",  bus.arb_busy, 1);
        check("nowd_rdy",   bus.d_ready,  0);
        check("nowd_err",   bus.arb_err,  0);
        check("nowd_req",   bus.mem_req,  1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
